// File: rtl/cgra0_conf_distributor.sv
// -----------------------------------------------------------------------------
// cgra0_conf_distributor
//
// Takes the 64-bit configuration word stream coming out of the CGRA
// configuration controller, buffers it in a small FIFO and hands each word's
// payload to the PE named in its top byte, using a one-hot write strobe once
// that PE reports ready. Words naming a PE that does not exist are discarded.
//
// Ports:
//   clk                  - clock, all state on the rising edge
//   rst                  - asynchronous active-low reset
//   clear                - synchronous clear of counter and sticky flags
//                          (buffered words are kept)
//   conf_in[63:0]        - word stream; [63:56] PE id, [55:0] payload,
//                          all-zero means no word this cycle
//   conf_pe_ready        - per-PE ready flags
//   conf_pe_data[55:0]   - payload broadcast to all PEs
//   conf_pe_we           - registered one-hot write strobe
//   conf_words_delivered - words delivered since reset/clear (wraps)
//   conf_overflow        - sticky: a word was dropped on a full FIFO
//   conf_bad_id          - sticky: a word with id >= NUM_PE was discarded
//   idle                 - FIFO empty and no strobe active (registered)
// -----------------------------------------------------------------------------
module cgra0_conf_distributor #(
  parameter int NUM_PE     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [63:0]       conf_in,
  input  logic [NUM_PE-1:0] conf_pe_ready,
  output logic [55:0]       conf_pe_data,
  output logic [NUM_PE-1:0] conf_pe_we,
  output logic [CNT_W-1:0]  conf_words_delivered,
  output logic              conf_overflow,
  output logic              conf_bad_id,
  output logic              idle
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [8:0]    NUM_PE_C = 9'(NUM_PE);

  typedef enum logic [0:0] {
    ISSUE_IDLE = 1'b0,
    ISSUE_HEAD = 1'b1
  } issue_state_t;

  logic [63:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  issue_state_t      state;
  issue_state_t      state_next;

  logic              push_req;
  logic              push;
  logic              pop;
  logic              full;
  logic              issue;
  logic              bad_pop;
  logic [63:0]       head;
  logic [7:0]        head_id;
  logic              head_bad;
  logic [NUM_PE-1:0] head_sel;
  logic              head_ready;
  logic [NUM_PE-1:0] we_next;
  logic [55:0]       data_next;

  assign push_req = (conf_in != 64'd0);
  assign full     = (count == DEPTH_C);
  assign head     = mem[rd_ptr];
  assign head_id  = head[63:56];
  // Compare in 9 bits so NUM_PE up to 255 never truncates.
  assign head_bad = ({1'b0, head_id} >= NUM_PE_C);

  // Decode the head id into a one-hot PE select (all-zero for a bad id).
  always_comb begin
    head_sel = {NUM_PE{1'b0}};
    for (int i = 0; i < NUM_PE; i++) begin
      head_sel[i] = (head_id == 8'(i));
    end
  end

  assign head_ready = |(head_sel & conf_pe_ready);

  // Issue decision: pop/discard/strobe for the head word.
  always_comb begin
    pop       = 1'b0;
    issue     = 1'b0;
    bad_pop   = 1'b0;
    we_next   = {NUM_PE{1'b0}};
    data_next = conf_pe_data;
    case (state)
      ISSUE_IDLE: begin
        pop = 1'b0;
      end
      ISSUE_HEAD: begin
        if (count == {CW{1'b0}}) begin
          pop = 1'b0;
        end else if (head_bad) begin
          pop     = 1'b1;
          bad_pop = 1'b1;
        end else if (head_ready) begin
          pop       = 1'b1;
          issue     = 1'b1;
          we_next   = head_sel;
          data_next = head[55:0];
        end else begin
          pop = 1'b0;
        end
      end
      default: begin
        pop = 1'b0;
      end
    endcase
  end

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push = push_req && (!full || pop);

  // Next occupancy and next issue state; the state follows the occupancy
  // so a word pushed at one edge can be issued at the very next edge.
  always_comb begin
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    if (count_next != {CW{1'b0}}) begin
      state_next = ISSUE_HEAD;
    end else begin
      state_next = ISSUE_IDLE;
    end
  end

  // FIFO pointers, occupancy and issue state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= {PW{1'b0}};
      wr_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
      state  <= ISSUE_IDLE;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_next;
      state <= state_next;
    end
  end

  // FIFO storage; contents are meaningless while count says empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= conf_in;
    end
  end

  // Registered PE outputs, counter, sticky flags and idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conf_pe_we           <= {NUM_PE{1'b0}};
      conf_pe_data         <= 56'd0;
      conf_words_delivered <= {CNT_W{1'b0}};
      conf_overflow        <= 1'b0;
      conf_bad_id          <= 1'b0;
      idle                 <= 1'b1;
    end else begin
      conf_pe_we   <= we_next;
      conf_pe_data <= data_next;
      idle         <= (count_next == {CW{1'b0}}) && (we_next == {NUM_PE{1'b0}});
      if (clear) begin
        conf_words_delivered <= {CNT_W{1'b0}};
        conf_overflow        <= 1'b0;
        conf_bad_id          <= 1'b0;
      end else begin
        if (issue) begin
          conf_words_delivered <= conf_words_delivered + CNT_W'(1);
        end
        if (push_req && full && !pop) begin
          conf_overflow <= 1'b1;
        end
        if (bad_pop) begin
          conf_bad_id <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cgra0_conf_distributor.sv
// -----------------------------------------------------------------------------
// Bench for cgra0_conf_distributor. Stimulus pushes the expected {PE, payload}
// of every word that should be delivered into a queue; a monitor on the
// falling edge pops one entry per observed strobe and compares it.
// -----------------------------------------------------------------------------
module tb_cgra0_conf_distributor;

  localparam int NUM_PE = 16;

  typedef struct packed {
    logic [7:0]  pe;
    logic [55:0] payload;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              clear;
  logic [63:0]       conf_in;
  logic [NUM_PE-1:0] conf_pe_ready;
  logic [55:0]       conf_pe_data;
  logic [NUM_PE-1:0] conf_pe_we;
  logic [31:0]       conf_words_delivered;
  logic              conf_overflow;
  logic              conf_bad_id;
  logic              idle;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  cgra0_conf_distributor #(
    .NUM_PE(NUM_PE),
    .FIFO_DEPTH(4),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .conf_in(conf_in),
    .conf_pe_ready(conf_pe_ready),
    .conf_pe_data(conf_pe_data),
    .conf_pe_we(conf_pe_we),
    .conf_words_delivered(conf_words_delivered),
    .conf_overflow(conf_overflow),
    .conf_bad_id(conf_bad_id),
    .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [7:0] id, input logic [55:0] pl);
    return {id, pl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [7:0] pe, input logic [55:0] pl);
    exp_t e;
    e.pe      = pe;
    e.payload = pl;
    exp_q.push_back(e);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  initial begin
    exp_t        e;
    logic [15:0] exp_we;
    forever begin
      @(negedge clk);
      if (rst && (conf_pe_we != 16'd0)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: got we=%h data=%h, required no strobe",
                   conf_pe_we, conf_pe_data);
        end else begin
          e      = exp_q.pop_front();
          exp_we = 16'd1 << e.pe;
          if (conf_pe_we !== exp_we || conf_pe_data !== e.payload) begin
            errors++;
            $display("FAIL strobe: got we=%h data=%h, required we=%h data=%h",
                     conf_pe_we, conf_pe_data, exp_we, e.payload);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stall_strobe;
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    clear         = 1'b0;
    conf_in       = 64'd0;
    conf_pe_ready = 16'hFFFF;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_we", 64'(conf_pe_we), 64'd0);
    chk("rst_data", 64'(conf_pe_data), 64'd0);
    chk("rst_cnt", 64'(conf_words_delivered), 64'd0);
    chk("rst_ovf", 64'(conf_overflow), 64'd0);
    chk("rst_bad", 64'(conf_bad_id), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    rst = 1'b1;
    tick();
    tick();

    // Single word: strobe exactly two cycles after the word
    conf_in = 64'h0300_0000_0000_00AB;
    expect_word(8'd3, 56'hAB);
    tick();
    conf_in = 64'd0;
    @(negedge clk);
    chk("t1_c1_we", 64'(conf_pe_we), 64'd0);
    chk("t1_c1_idle", 64'(idle), 64'd0);
    tick();
    @(negedge clk);
    chk("t1_c2_we", 64'(conf_pe_we), 64'h0008);
    chk("t1_c2_data", 64'(conf_pe_data), 64'hAB);
    chk("t1_c2_cnt", 64'(conf_words_delivered), 64'd1);
    tick();
    @(negedge clk);
    chk("t1_c3_we", 64'(conf_pe_we), 64'd0);
    chk("t1_c3_idle", 64'(idle), 64'd1);
    tick();

    // Stall on PE 5, then three back-to-back strobes
    pulse_clear();
    conf_pe_ready = ~(16'd1 << 5);
    for (int i = 0; i < 3; i++) begin
      conf_in = mk(8'd5, 56'h501 + 56'(i));
      expect_word(8'd5, 56'h501 + 56'(i));
      tick();
    end
    conf_in      = 64'd0;
    stall_strobe = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (conf_pe_we != 16'd0) stall_strobe = 1'b1;
      tick();
    end
    chk("t2_stall_no_strobe", 64'(stall_strobe), 64'd0);
    chk("t2_stall_idle", 64'(idle), 64'd0);
    conf_pe_ready = 16'hFFFF;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_b2b_we", 64'(conf_pe_we), 64'h0020);
      tick();
    end
    chk("t2_cnt", 64'(conf_words_delivered), 64'd3);
    chk("t2_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) tick();

    // Overflow: PE 0 never ready, six words into a four-deep FIFO
    pulse_clear();
    conf_pe_ready = ~16'd1;
    for (int i = 0; i < 6; i++) begin
      conf_in = mk(8'd0, 56'h11 + 56'(i));
      if (i < 4) expect_word(8'd0, 56'h11 + 56'(i));
      tick();
    end
    conf_in = 64'd0;
    @(negedge clk);
    chk("t3_ovf", 64'(conf_overflow), 64'd1);
    chk("t3_we", 64'(conf_pe_we), 64'd0);
    tick();
    conf_pe_ready = 16'hFFFF;
    wait_drain(20);
    chk("t3_cnt", 64'(conf_words_delivered), 64'd4);
    chk("t3_idle", 64'(idle), 64'd1);

    // Full FIFO with a pop in the same cycle as a new word
    pulse_clear();
    chk("t4_ovf_cleared", 64'(conf_overflow), 64'd0);
    conf_pe_ready = ~(16'd1 << 2);
    for (int i = 0; i < 4; i++) begin
      conf_in = mk(8'd2, 56'h200 + 56'(i));
      expect_word(8'd2, 56'h200 + 56'(i));
      tick();
    end
    conf_in = mk(8'd2, 56'h204);
    expect_word(8'd2, 56'h204);
    conf_pe_ready = 16'hFFFF;
    tick();
    conf_in = 64'd0;
    @(negedge clk);
    chk("t4_no_ovf", 64'(conf_overflow), 64'd0);
    tick();
    wait_drain(20);
    chk("t4_cnt", 64'(conf_words_delivered), 64'd5);
    chk("t4_no_ovf_end", 64'(conf_overflow), 64'd0);

    // Reset mid-stream with three words buffered for a stalled PE 7
    conf_pe_ready = ~(16'd1 << 7);
    for (int i = 0; i < 3; i++) begin
      conf_in = mk(8'd7, 56'h701 + 56'(i));
      tick();
    end
    conf_in = 64'd0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("t6_we", 64'(conf_pe_we), 64'd0);
    chk("t6_idle", 64'(idle), 64'd1);
    chk("t6_cnt", 64'(conf_words_delivered), 64'd0);
    tick();
    rst = 1'b1;
    conf_pe_ready = 16'hFFFF;
    repeat (10) tick();
    chk("t6_idle_after", 64'(idle), 64'd1);
    chk("t6_cnt_after", 64'(conf_words_delivered), 64'd0);
    conf_in = mk(8'd9, 56'h999);
    expect_word(8'd9, 56'h999);
    tick();
    conf_in = 64'd0;
    wait_drain(20);
    chk("t6_cnt_new", 64'(conf_words_delivered), 64'd1);

    // Bad id followed by a good word, then clear
    pulse_clear();
    conf_in = mk(8'h20, 56'h55);
    tick();
    conf_in = mk(8'd1, 56'h66);
    expect_word(8'd1, 56'h66);
    tick();
    conf_in = 64'd0;
    wait_drain(20);
    chk("t5_bad", 64'(conf_bad_id), 64'd1);
    chk("t5_cnt", 64'(conf_words_delivered), 64'd1);
    pulse_clear();
    chk("t5_clr_cnt", 64'(conf_words_delivered), 64'd0);
    chk("t5_clr_bad", 64'(conf_bad_id), 64'd0);

    repeat (3) tick();
    chk("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cgra0_conf_distributor.md
Name: cgra0_conf_distributor

Overview:
- Sits directly downstream of the CGRA configuration controller.
- Consumes the 64-bit configuration word stream on conf_in. A word is present when the bus is non-zero; the bus is all-zero when idle.
- Buffers words in a small FIFO and decodes the target PE id from each word.
- Delivers the payload to the addressed PE with a one-hot write strobe once that PE reports ready, and reports delivery count and error flags.

Parameters:
- NUM_PE, 16, number of configurable PEs; legal range 1..255.
- FIFO_DEPTH, 4, word buffer depth; must be a power of 2, at least 2.
- CNT_W, 32, width of the delivered-word counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of the counter and sticky flags; does not flush the FIFO.
- conf_in  input  64  config word stream. Bits [63:56] are the target PE id; bits [55:0] are the payload. All-zero means no word.
- conf_pe_ready  input  NUM_PE  per-PE "can accept a config word" flag.
- conf_pe_data  output  56  payload broadcast to all PEs.
- conf_pe_we  output  NUM_PE  one-hot write strobe.
- conf_words_delivered  output  CNT_W  number of words delivered since reset or clear.
- conf_overflow  output  1  sticky: a word arrived while the FIFO was full and was dropped.
- conf_bad_id  output  1  sticky: a word with id >= NUM_PE was discarded.
- idle  output  1  high when the FIFO is empty and no strobe is active.

Behaviour:

Reset (rst low, asynchronous):
- FIFO empty; conf_pe_we=0; conf_pe_data=0; conf_words_delivered=0; conf_overflow=0; conf_bad_id=0; idle=1.
- Reset asserted mid-operation discards every buffered word immediately.
- No strobe is issued in the first cycle after reset release.

Input capture:
- Any cycle with conf_in != 0 pushes the word at the rising edge.
- There is no backpressure to upstream.
- A word with id 0 and payload 0 is indistinguishable from idle and is never delivered.

Overflow and simultaneous events:
- If the FIFO is full and no pop happens in the same cycle, the incoming word is dropped and conf_overflow is set.
- If the FIFO is full and a pop happens in the same cycle, the push is accepted and no overflow is flagged.
- Push and pop may occur in the same cycle at any occupancy.

Issue state machine (two states):
- ISSUE_IDLE:
  - Entered when the FIFO is empty. Outputs conf_pe_we=0; conf_pe_data holds its last value.
  - Moves to ISSUE_HEAD when the FIFO becomes non-empty.
- ISSUE_HEAD:
  - The FIFO head has id h.
  - If h >= NUM_PE: pop the head, set conf_bad_id, pulse no strobe. Costs one cycle and does not increment the counter.
  - Else if conf_pe_ready[h]=1 at the rising edge: pop the head; in the next cycle drive conf_pe_we = 1<<h for exactly one cycle and conf_pe_data = payload; increment the counter.
  - Else: stall and hold the head. There is no timeout and no head-of-line bypass.
  - Returns to ISSUE_IDLE when the FIFO becomes empty.

Throughput and latency:
- At most one word issued per cycle; back-to-back strobes allowed, including to the same PE.
- Minimum latency: word on conf_in in cycle T gives conf_pe_we high in cycle T+2, provided the target is ready in T+1.

Output and flag rules:
- conf_pe_we is registered and at most one bit is set.
- Counter wraps modulo 2^CNT_W.
- clear has priority over a same-cycle increment or flag set: counter goes to 0 and flags go to 0.
- idle = FIFO empty AND conf_pe_we == 0, registered-equivalent, with no combinational path from conf_in.

Test Plan:
- Single word: conf_in=0x0300_0000_0000_00AB in cycle 0, all PEs ready -> conf_pe_we=0x0008 and conf_pe_data=0x00_0000_0000_00AB in cycle 2 only; counter=1; idle returns to 1 in cycle 3.
- Stall: 3 words to PE 5 with conf_pe_ready[5]=0 for 10 cycles -> no strobe. Then raise ready -> three consecutive strobes of 0x0020 with payloads in order; counter=3.
- Overflow: PE 0 never ready; push 6 consecutive words with FIFO_DEPTH=4 -> 4 buffered, conf_overflow=1. Release ready -> exactly the first 4 payloads delivered.
- Full plus pop: FIFO full and head ready in the same cycle a new word arrives -> no overflow; all 5 words delivered.
- Bad id: word id 0x20 (32 >= 16) followed by a word to PE 1 -> conf_bad_id=1, no strobe for the bad word, PE 1 strobed; counter=1. Then pulse clear -> counter=0, conf_bad_id=0.
- Reset mid-stream: 3 words buffered, assert rst low asynchronously -> conf_pe_we=0 immediately, FIFO empty. After release, no strobes until new input arrives.
